// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator with a pixel-clock divider and a per-frame
// latched, priority-encoded key input (lowest held note wins).
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [2:0]  KEY_NONE = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] keys,
  output logic       pix_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic       frame_start,
  output logic [2:0] key_press
);

  localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam logic [9:0] HLast      = 10'd799;
  localparam logic [9:0] HVisible   = 10'd640;
  localparam logic [9:0] HSyncFirst = 10'd656;
  localparam logic [9:0] HSyncLast  = 10'd751;
  localparam logic [9:0] VLast      = 10'd524;
  localparam logic [9:0] VVisible   = 10'd480;
  localparam logic [9:0] VSyncFirst = 10'd490;
  localparam logic [9:0] VSyncLast  = 10'd491;

  logic [DivW-1:0] div_q;
  logic [DivW-1:0] div_d;
  logic [9:0]      h_d;
  logic [9:0]      v_d;
  logic            h_wrap;
  logic            frame_wrap;
  logic [6:0]      keys_meta_q;
  logic [6:0]      keys_sync_q;
  logic [2:0]      key_enc;

  assign pix_tick   = (div_q == DivLast);
  assign h_wrap     = pix_tick && (h_cnt == HLast);
  assign frame_wrap = h_wrap && (v_cnt == VLast);

  always_comb begin
    div_d = pix_tick ? '0 : div_q + DivW'(1);

    h_d = h_cnt;
    if (pix_tick) begin
      h_d = h_wrap ? 10'd0 : h_cnt + 10'd1;
    end

    v_d = v_cnt;
    if (h_wrap) begin
      v_d = (v_cnt == VLast) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Scan from the top down so the lowest-index held key is the last to win.
  always_comb begin
    key_enc = KEY_NONE;
    for (int i = 6; i >= 0; i--) begin
      if (keys_sync_q[i]) begin
        key_enc = 3'(i);
      end
    end
  end

  // Sync and valid are derived from the next counter values so that they line
  // up with h_cnt/v_cnt in the same cycle instead of lagging by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      valid       <= 1'b1;
      frame_start <= 1'b0;
      key_press   <= KEY_NONE;
      keys_meta_q <= 7'd0;
      keys_sync_q <= 7'd0;
    end else begin
      div_q       <= div_d;
      h_cnt       <= h_d;
      v_cnt       <= v_d;
      hsync       <= !((h_d >= HSyncFirst) && (h_d <= HSyncLast));
      vsync       <= !((v_d >= VSyncFirst) && (v_d <= VSyncLast));
      valid       <= (h_d < HVisible) && (v_d < VVisible);
      frame_start <= frame_wrap;
      keys_meta_q <= keys;
      keys_sync_q <= keys_meta_q;
      if (frame_wrap) begin
        key_press <= key_enc;
      end
    end
  end

endmodule
